// File: rtl/filt_address_calc.sv
// -----------------------------------------------------------------------------
// filt_address_calc
//   Sequential address generator for the filter data path. While enable is
//   high it issues one address per clock over a contiguous window
//   offset, offset+STEP, ..., offset+(filesize-1)*STEP and raises done while
//   the last address of the window is on the bus. Dropping enable aborts the
//   run and returns the block to IDLE with addr=0, done=0.
//
//   Configuration macro: FILT_ADDR_CALC_LOOP_EN
//     defined   : after the last address the window restarts from the latched
//                 offset (circular sweep, done pulses once per pass).
//     undefined : the last address and done are held while enable stays high.
//
// Parameters
//   ADDR_W    width of offset, filesize, addr and the internal counter
//   STEP      address increment per clock (unsigned)
//
// Ports
//   clk       in   clock, all state updates on posedge
//   rst_n     in   asynchronous active-low reset
//   offset    in   window start address, sampled only when a run starts
//   filesize  in   number of addresses to issue, sampled only at run start
//   enable    in   level: 1 = run/hold, 0 = abort to IDLE
//   addr      out  current address (registered)
//   done      out  high while the last address is presented (registered)
// -----------------------------------------------------------------------------
module filt_address_calc #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned STEP   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] offset,
    input  logic [ADDR_W-1:0] filesize,
    input  logic              enable,
    output logic [ADDR_W-1:0] addr,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ZERO_C = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_C  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] STEP_C = ADDR_W'(STEP);

    state_t            state_q,  state_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic              done_q,   done_d;
    logic [ADDR_W-1:0] count_q,  count_d;
    logic [ADDR_W-1:0] size_q,   size_d;
    logic [ADDR_W-1:0] offset_q, offset_d;

    logic [ADDR_W-1:0] count_inc_s;
    logic [ADDR_W-1:0] size_last_s;

    // Index of the next address and index of the final address of the window.
    always_comb begin
        count_inc_s = count_q + ONE_C;
        size_last_s = size_q - ONE_C;
    end

    // Next-state and output logic; enable low overrides every state.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        done_d   = done_q;
        count_d  = count_q;
        size_d   = size_q;
        offset_d = offset_q;

        if (!enable) begin
            state_d = ST_IDLE;
            addr_d  = ZERO_C;
            done_d  = 1'b0;
            count_d = ZERO_C;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    offset_d = offset;
                    size_d   = filesize;
                    addr_d   = offset;
                    count_d  = ZERO_C;
                    // filesize 0 and 1 both present just the offset with done.
                    if (filesize <= ONE_C) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        done_d  = 1'b0;
                    end
                end
                ST_RUN: begin
                    addr_d  = addr_q + STEP_C;
                    count_d = count_inc_s;
                    if (count_inc_s == size_last_s) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        done_d  = 1'b0;
                    end
                end
                ST_FIN: begin
`ifdef FILT_ADDR_CALC_LOOP_EN
                    addr_d  = offset_q;
                    count_d = ZERO_C;
                    if (size_q <= ONE_C) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        done_d  = 1'b0;
                    end
`else
                    state_d = ST_FIN;
                    addr_d  = addr_q;
                    done_d  = 1'b1;
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                    addr_d  = ZERO_C;
                    done_d  = 1'b0;
                    count_d = ZERO_C;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= ZERO_C;
            done_q   <= 1'b0;
            count_q  <= ZERO_C;
            size_q   <= ZERO_C;
            offset_q <= ZERO_C;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            done_q   <= done_d;
            count_q  <= count_d;
            size_q   <= size_d;
            offset_q <= offset_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        addr = addr_q;
        done = done_q;
    end

endmodule

// File: tb/tb_filt_address_calc.sv
module tb_filt_address_calc;

    localparam int AW = 32;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] offset;
    logic [AW-1:0] filesize;
    logic          enable;
    logic [AW-1:0] addr;
    logic          done;

    int n_vec;
    int n_err;

    filt_address_calc #(.ADDR_W(AW), .STEP(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .offset   (offset),
        .filesize (filesize),
        .enable   (enable),
        .addr     (addr),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: k-th clock after a run start (k=0 is the first address).
    task automatic model(input longint o, input longint n, input longint k,
                         output logic [AW-1:0] ea, output logic ed);
        longint idx;
`ifdef FILT_ADDR_CALC_LOOP_EN
        if (n <= 1) begin
            idx = 0;
            ed  = 1'b1;
        end else begin
            idx = k % n;
            ed  = (idx == n - 1);
        end
`else
        if (n <= 1) begin
            idx = 0;
            ed  = 1'b1;
        end else begin
            idx = (k < n - 1) ? k : n - 1;
            ed  = (k >= n - 1);
        end
`endif
        ea = AW'(o + idx);
    endtask

    task automatic check(input string tag, input logic [AW-1:0] ea, input logic ed);
        n_vec++;
        assert (addr === ea && done === ed) else begin
            n_err++;
            $error("FAIL %s: got addr=%0d done=%0b, want addr=%0d done=%0b",
                   tag, addr, done, ea, ed);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a window and check `cycles` clocks; optionally scramble
    // offset/filesize at clock chg_at (they must be ignored). Ends with abort.
    task automatic run(input string tag, input logic [AW-1:0] o, input logic [AW-1:0] n,
                       input int cycles, input int chg_at);
        logic [AW-1:0] ea;
        logic          ed;
        offset   = o;
        filesize = n;
        enable   = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            step();
            model(longint'(o), longint'(n), longint'(k), ea, ed);
            check(tag, ea, ed);
            if (k == chg_at) begin
                offset   = 32'd500 + $urandom_range(0, 1000);
                filesize = $urandom_range(0, 50);
            end
        end
        enable = 1'b0;
        step();
        check({tag, "_abort"}, 32'd0, 1'b0);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        enable   = 1'b1;
        offset   = 32'd55;
        filesize = 32'd4;

        // Reset held with enable high: outputs stay zero across edges.
        #2;
        check("reset_async", 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_held", 32'd0, 1'b0);
        end
        rst_n = 1'b1;
        run("reset_release", 32'd55, 32'd4, 6, -1);

        // Long window with done hold.
        run("long", 32'd1000, 32'd10000, 10005, -1);

        // Abort for several clocks then a fresh window.
        enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("idle", 32'd0, 1'b0);
        end
        run("restart", 32'd100524, 32'd1000, 19, -1);

        // Degenerate sizes.
        run("size1", 32'd7, 32'd1, 5, -1);
        run("size0", 32'd300, 32'd0, 4, -1);

        // Mid-run input change is ignored.
        run("midchg", 32'd0, 32'd8, 12, 3);

        // Short window (circular when looping is compiled in).
        run("win3", 32'd20, 32'd3, 10, -1);

        // Wrap across 2^ADDR_W.
        run("wrap", 32'hFFFF_FFFE, 32'd5, 8, -1);

        // Reset asserted mid-run.
        offset   = 32'd50;
        filesize = 32'd10;
        enable   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("prerst", 32'd50 + 32'(k), 1'b0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_async", 32'd0, 1'b0);
        step();
        check("midrst_held", 32'd0, 1'b0);
        enable = 1'b0;
        rst_n  = 1'b1;
        step();
        check("midrst_release", 32'd0, 1'b0);

        // Randomized windows.
        for (int r = 0; r < 25; r++) begin
            logic [AW-1:0] ro;
            logic [AW-1:0] rn;
            ro = $urandom;
            rn = $urandom_range(0, 24);
            run("rand", ro, rn, int'(rn) + $urandom_range(1, 12),
                $urandom_range(0, 1) == 1 ? $urandom_range(0, 5) : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
